// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundles the fetch unit's external handshakes. These are the
//            instruction-memory req/ack port, the execute-stage redirect, and
//            the valid/ready instruction stream toward decode.
// Modports : master - fetch unit side (drives imem_req/addr and the instruction
//                     stream; receives ack/rdata, redirect and instr_ready)
//            slave  - environment side (memory, execute and decode)
// Signals  : imem_req, imem_addr, imem_ack, imem_rdata,
//            branch_taken, branch_target,
//            instr_valid, instr_ready, instr, instr_pc
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  branch_taken, branch_target,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output branch_taken, branch_target,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage. Holds the PC and issues one outstanding 16-bit fetch
//            at a time over a req/ack memory port. Fetched instructions are
//            buffered in a DEPTH-entry FIFO and handed to decode with
//            valid/ready. A branch redirect flushes the FIFO, discards any
//            in-flight response and restarts fetch at the target.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            fetch_bus  - instr_fetch_unit_if.master (memory, redirect and
//                         decode handshakes)
//            stall_cnt  - (FETCH_STALL_CNT_EN only) saturating count of
//                         cycles with no valid instruction at the FIFO head
// Config   : `define FETCH_STALL_CNT_EN adds the stall_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  instr_fetch_unit_if.master fetch_bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                  c_ptr_w      = $clog2(DEPTH);
  localparam int                  c_cnt_w      = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_depth      = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0]  c_ptr_one    = c_ptr_w'(1);
  localparam logic [ADDR_W-1:0]   c_pc_step    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0]   c_align_mask = ~ADDR_W'(1);

  // S_DROP: a redirect arrived while a request was in flight. The request
  // cannot be withdrawn, so we wait for its ack and throw the data away.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_req;
  logic [ADDR_W-1:0]   r_req_addr;

  logic [DATA_W-1:0]   r_fifo_data [DEPTH];
  logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                w_redirect;
  logic [ADDR_W-1:0]   w_target;
  logic                w_push;
  logic                w_pop;
  logic                w_instr_valid;

  assign w_redirect    = fetch_bus.branch_taken;
  assign w_target      = fetch_bus.branch_target & c_align_mask;
  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid && fetch_bus.instr_ready;

  // Only a clean ack in S_REQ delivers data. An ack in S_DROP, or an ack that
  // coincides with a redirect, belongs to the abandoned path.
  assign w_push = (r_state == S_REQ) && fetch_bus.imem_ack && !w_redirect;

  // --------------------------------------------------------------------------
  // Fetch FSM: at most one request outstanding. imem_req/imem_addr are
  // registered and stay stable from issue until the ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC & c_align_mask;
      r_req      <= 1'b0;
      r_req_addr <= RESET_PC & c_align_mask;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            // Spend one cycle absorbing the new PC before issuing.
            r_pc <= w_target;
          end else if (r_count < c_depth) begin
            // A free slot is guaranteed for the response: no other request
            // can be in flight, and pops only free more space.
            r_req      <= 1'b1;
            r_req_addr <= r_pc;
            r_state    <= S_REQ;
          end
        end

        S_REQ: begin
          if (fetch_bus.imem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            // Sequential PC wraps naturally at 2^ADDR_W.
            r_pc    <= w_redirect ? w_target : (r_pc + c_pc_step);
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_DROP;
          end
        end

        S_DROP: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (fetch_bus.imem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction FIFO storage. Entries are reset so that the head reads as zero
  // out of reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= fetch_bus.imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_req_addr;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy. A redirect empties the FIFO outright and
  // overrides any push or pop in the same cycle. DEPTH is a power of two, so
  // the pointers wrap by plain overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fetch_bus.imem_req    = r_req;
  assign fetch_bus.imem_addr   = r_req_addr;
  assign fetch_bus.instr_valid = w_instr_valid;
  assign fetch_bus.instr       = r_fifo_data[r_rd_ptr];
  assign fetch_bus.instr_pc    = r_fifo_pc[r_rd_ptr];

`ifdef FETCH_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Decode-starvation counter: cycles with nothing valid at the FIFO head.
  // It saturates instead of wrapping.
  // --------------------------------------------------------------------------
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_instr_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit. A randomized memory /
//            execute / decode environment drives the DUT. A reference model
//            tracks the architectural PC and the set of instructions that
//            should survive redirects, and queues the expected stream. A
//            separate monitor pops that queue at every decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  localparam int          DATA_W   = 16;
  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .fetch_bus (bus.master)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int passes = 0;
  int delivered = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory image: a fixed scramble of the byte address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A ^ {a[7:0], a[15:8]};
  endfunction

  // -------------------------------------------------------------------- knobs
  int          p_branch  = 0;    // percent chance of a random redirect
  int          p_ready   = 100;  // percent chance decode is ready
  int          min_delay = 0;    // ack wait range, in cycles after req seen
  int          max_delay = 0;
  bit          no_ack    = 1'b0;
  int          force_mode = 0;   // 0: now, 1: mid-wait (no ack), 2: with ack
  logic [15:0] force_target = 16'h0;
  int          force_seq  = 0;
  int          force_done = 0;

  // ------------------------------------------------- environment driver
  int          wait_left = -1;
  logic        drv_ack;
  logic        drv_br;
  logic [15:0] drv_tgt;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = '0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.instr_ready   = 1'b0;
      wait_left = -1;
    end else begin
      drv_ack = 1'b0;
      if (bus.imem_req) begin
        if (wait_left < 0) wait_left = int'($urandom_range(max_delay, min_delay));
        if (wait_left == 0) begin
          if (!no_ack) begin
            drv_ack   = 1'b1;
            wait_left = -1;
          end
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
      drv_br  = ($urandom_range(0, 99) < p_branch);
      drv_tgt = 16'($urandom_range(0, 65535));
      if (force_done != force_seq) begin
        case (force_mode)
          1: if (bus.imem_req && !drv_ack) begin
               drv_br = 1'b1; drv_tgt = force_target; force_done = force_seq;
             end
          2: if (drv_ack) begin
               drv_br = 1'b1; drv_tgt = force_target; force_done = force_seq;
             end
          default: begin
               drv_br = 1'b1; drv_tgt = force_target; force_done = force_seq;
             end
        endcase
      end
      bus.imem_ack      = drv_ack;
      bus.imem_rdata    = drv_ack ? mem_word(bus.imem_addr) : 16'($urandom);
      bus.branch_taken  = drv_br;
      bus.branch_target = drv_tgt;
      bus.instr_ready   = ($urandom_range(0, 99) < p_ready);
    end
  end

  // ----------------------------------------------------- reference model
  // Architectural rules: a fetch is delivered only if no redirect occurred
  // between its issue and its ack (inclusive). A redirect discards everything
  // still buffered and moves the PC to the target with bit 0 cleared. Each
  // delivered fetch advances the PC by 2 modulo 2^16.
  logic [31:0] exp_q[$];  // {pc, instr}
  logic [15:0] model_pc  = RESET_PC;
  logic        prev_req  = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        taint     = 1'b0;
  logic        new_req;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (exp_q.size() == DEPTH)
        check(!bus.imem_req, "no_req_when_full", 32'(bus.imem_req), 32'h0);
      new_req = bus.imem_req && !prev_req;
      if (new_req) begin
        check(bus.imem_addr == model_pc, "req_addr", 32'(bus.imem_addr), 32'(model_pc));
        check(exp_q.size() < DEPTH, "issue_with_space", 32'(exp_q.size()), 32'(DEPTH - 1));
        taint = 1'b0;
      end else if (prev_req) begin
        check(bus.imem_req && (bus.imem_addr == prev_addr), "req_held",
              {15'h0, bus.imem_req, bus.imem_addr}, {16'h1, prev_addr});
      end
      if (bus.imem_req && bus.imem_ack && !taint && !bus.branch_taken) begin
        exp_q.push_back({bus.imem_addr, mem_word(bus.imem_addr)});
        model_pc = model_pc + 16'd2;
      end
      if (bus.branch_taken) begin
        exp_q.delete();
        model_pc = bus.branch_target & 16'hFFFE;
        if (bus.imem_req) taint = 1'b1;
      end
      prev_req  = bus.imem_req && !bus.imem_ack;
      prev_addr = bus.imem_addr;
    end
  end

  // ---------------------------------------------------------------- monitor
  logic        prev_branch = 1'b0;
  logic [31:0] exp_e;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_model = '0;
`endif

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_branch)
        check(!bus.instr_valid, "valid_after_flush", 32'(bus.instr_valid), 32'h0);
      if (bus.instr_valid && bus.instr_ready && !bus.branch_taken) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_instr", {bus.instr_pc, bus.instr}, 32'h0);
        end else begin
          exp_e = exp_q.pop_front();
          check({bus.instr_pc, bus.instr} == exp_e, "instr_stream",
                {bus.instr_pc, bus.instr}, exp_e);
          delivered++;
        end
      end
      prev_branch = bus.branch_taken;
`ifdef FETCH_STALL_CNT_EN
      check(stall_cnt == stall_model, "stall_cnt", 32'(stall_cnt), 32'(stall_model));
      if (!bus.instr_valid && stall_model != 16'hFFFF) stall_model++;
`endif
    end
  end

  // ------------------------------------------------------------ sequencing
  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_force(input int mode, input logic [15:0] tgt, input int budget);
    force_mode   = mode;
    force_target = tgt;
    force_seq++;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (force_done == force_seq) break;
    end
    check(force_done == force_seq, "redirect_opportunity", 32'(force_done), 32'(force_seq));
  endtask

  initial begin
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready   = 1'b0;
    rst_n = 1'b0;
    run(3);
    #2;
    check(bus.imem_req == 1'b0,      "reset_req",   32'(bus.imem_req),    32'h0);
    check(bus.imem_addr == RESET_PC, "reset_addr",  32'(bus.imem_addr),   32'(RESET_PC));
    check(bus.instr_valid == 1'b0,   "reset_valid", 32'(bus.instr_valid), 32'h0);
    check(bus.instr == '0,           "reset_instr", 32'(bus.instr),       32'h0);
    check(bus.instr_pc == '0,        "reset_pc",    32'(bus.instr_pc),    32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Streaming with immediate acks and decode always ready.
    run(40);
    // Backpressure: the FIFO fills, then fetching must pause.
    p_ready = 0;
    run(20);
    // Redirect while full and idle: the buffered entries are dropped.
    do_force(0, 16'h0040, 4);
    run(3);
    p_ready = 100;
    run(20);
    // Redirect while an ack is delayed by 3 cycles (odd target).
    min_delay = 3; max_delay = 3;
    run(4);
    do_force(1, 16'h0081, 20);
    run(25);
    // Redirect coinciding with the ack.
    min_delay = 0; max_delay = 2;
    do_force(2, 16'h0100, 20);
    run(20);
    // PC wrap through 0xFFFE -> 0x0000.
    min_delay = 0; max_delay = 0;
    do_force(0, 16'hFFFC, 4);
    run(20);
    // Randomized mix.
    p_branch = 8; p_ready = 70; min_delay = 0; max_delay = 3;
    run(1500);
    // Starve the FIFO: the outstanding request is never acked, so it drains.
    p_branch = 0; p_ready = 100; no_ack = 1'b1;
    run(20);
    #2;
    check(exp_q.size() == 0, "drained_queue", 32'(exp_q.size()), 32'h0);
    check(bus.instr_valid == 1'b0, "drained_valid", 32'(bus.instr_valid), 32'h0);
    check(delivered > 100, "delivery_progress", 32'(delivered), 32'd101);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
